// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command stream into APB transfers,
// with a wait-state timeout and a one-cycle response pulse per command.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NO_SLAVES      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [NO_SLAVES-1:0]  cmd_sel,

    output logic [NO_SLAVES-1:0]  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            err_pend;
    logic            sel_ok;
    logic            accept;
    logic            launch;
    logic            timeout_hit;

    assign sel_ok      = $onehot(cmd_sel);
    assign cmd_ready   = (state == IDLE && !err_pend)
                       || (state == ACCESS && PREADY);
    assign accept      = cmd_valid & cmd_ready;
    assign launch      = accept & sel_ok;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_CNT);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            wait_cnt    <= '0;
            err_pend    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    if (err_pend) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        err_pend  <= 1'b0;
                    end else if (accept && !sel_ok) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end

                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        PENABLE   <= 1'b0;
                        if (!launch) begin
                            PSEL  <= '0;
                            state <= IDLE;
                        end
                        // An illegal select taken at completion is answered
                        // one cycle later so the two pulses never collide.
                        err_pend <= accept & !sel_ok;
                    end else if (timeout_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        state       <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                default: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase

            if (launch) begin
                state    <= SETUP;
                PSEL     <= cmd_sel;
                PENABLE  <= 1'b0;
                PWRITE   <= cmd_write;
                PADDR    <= cmd_addr;
                PWDATA   <= cmd_write ? cmd_wdata : '0;
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table plus randomized transactions checked
// against a transaction-level latency/response model.
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [NS-1:0] cmd_sel;
    logic [NS-1:0] psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .NO_SLAVES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(clk), .PRESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
    );

    typedef struct {
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NS-1:0] sel;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            lat;
        logic          err;
        logic          to;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [NS-1:0] s,
                                input int waits, input logic [DW-1:0] rd,
                                input logic se, input int lat, input logic err,
                                input logic to, input logic [DW-1:0] rr);
        vec_t v;
        v.w = w; v.addr = a; v.wdata = d; v.sel = s;
        v.waits = waits; v.prdata = rd; v.slverr = se;
        v.lat = lat; v.err = err; v.to = to; v.rdata = rr;
        return v;
    endfunction

    // Expected outcome from the protocol rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if ($countones(v.sel) != 1) begin
            r.lat = 1; r.err = 1'b1; r.to = 1'b0; r.rdata = '0;
        end else if (v.waits > TO) begin
            r.lat = 3 + TO; r.err = 1'b1; r.to = 1'b1; r.rdata = '0;
        end else begin
            r.lat = 3 + v.waits; r.err = v.slverr; r.to = 1'b0;
            r.rdata = v.w ? '0 : v.prdata;
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v);
        bit legal = ($countones(v.sel) == 1);
        bit got = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_sel = v.sel;
        pready = 1'b0; prdata = $urandom; pslverr = 1'b1;
        #1 chk("ready_idle", cmd_ready, 1);
        for (int off = 1; off <= 40 && !got; off++) begin
            @(negedge clk);
            cmd_valid = 1'b0; cmd_write = $urandom;
            cmd_addr = $urandom; cmd_wdata = $urandom;
            cmd_sel = NS'($urandom);
            pready = (off >= 2 + v.waits);
            prdata = pready ? v.prdata : $urandom;
            pslverr = pready ? v.slverr : 1'($urandom);
            #1;
            if (rsp_valid) begin
                got = 1;
                chk("latency", off, v.lat);
                chk("rsp_err", rsp_err, v.err);
                chk("rsp_timeout", rsp_timeout, v.to);
                chk("rsp_rdata", rsp_rdata, v.rdata);
                chk("psel_done", psel, 0);
                chk("penable_done", penable, 0);
                if (legal) chk("paddr_keep", paddr, v.addr);
            end else if (legal) begin
                chk("psel", psel, v.sel);
                chk("penable", penable, off >= 2);
                chk("paddr", paddr, v.addr);
                chk("pwrite", pwrite, v.w);
                chk("pwdata", pwdata, v.w ? v.wdata : 0);
                chk("cmd_ready", cmd_ready, off >= 2 && pready);
            end else begin
                chk("psel_illegal", psel, 0);
            end
        end
        if (!got) chk("rsp_seen", 0, 1);
        @(negedge clk);
        pready = 1'b0;
        #1 chk("single_pulse", rsp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;

        tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'b0001, 0, 32'h0, 0,
                         3, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h20, 32'h0, 4'b0010, 3, 32'hA5A5A5A5, 0,
                         6, 0, 0, 32'hA5A5A5A5));
        tbl.push_back(mk(0, 32'h24, 32'h0, 4'b0100, 100, 32'h1234, 0,
                         19, 1, 1, 32'h0));
        tbl.push_back(mk(0, 32'h28, 32'h0, 4'b1000, 16, 32'h5555AAAA, 0,
                         19, 0, 0, 32'h5555AAAA));
        tbl.push_back(mk(1, 32'h2C, 32'h77, 4'b0001, 17, 32'h0, 0,
                         19, 1, 1, 32'h0));
        tbl.push_back(mk(1, 32'h30, 32'hCAFEF00D, 4'b0100, 1, 32'h0, 1,
                         4, 1, 0, 32'h0));
        tbl.push_back(mk(1, 32'h34, 32'h1, 4'b0000, 0, 32'h0, 0,
                         1, 1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h38, 32'h0, 4'b0110, 0, 32'h9, 0,
                         1, 1, 0, 32'h0));
        for (int i = 0; i < 30; i++) begin
            vec_t v;
            v.w = 1'($urandom); v.addr = $urandom; v.wdata = $urandom;
            v.sel = ($urandom_range(0, 4) == 0) ? NS'($urandom)
                  : NS'(1 << $urandom_range(0, NS - 1));
            v.waits = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20)
                    : $urandom_range(0, 4);
            v.prdata = $urandom; v.slverr = 1'($urandom);
            tbl.push_back(model(v));
        end
        foreach (tbl[i]) run_vec(tbl[i]);

        // back-to-back writes with cmd_valid held
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100;
        cmd_wdata = 32'h11111111; cmd_sel = 4'b0001; pready = 1'b0;
        #1 chk("b2b_ready_n", cmd_ready, 1);
        @(negedge clk);
        cmd_addr = 32'h104; cmd_wdata = 32'h22222222; cmd_sel = 4'b0100;
        #1 chk("b2b_setup_ready", cmd_ready, 0);
        chk("b2b_setup_psel", psel, 4'b0001);
        chk("b2b_setup_paddr", paddr, 32'h100);
        @(negedge clk);
        pready = 1'b1; pslverr = 1'b0;
        #1 chk("b2b_acc_ready", cmd_ready, 1);
        chk("b2b_acc_pen", penable, 1);
        @(negedge clk);
        cmd_valid = 1'b0; pready = 1'b0;
        #1 chk("b2b_rsp1", rsp_valid, 1);
        chk("b2b_rsp1_err", rsp_err, 0);
        chk("b2b_setup2_psel", psel, 4'b0100);
        chk("b2b_setup2_pen", penable, 0);
        chk("b2b_setup2_paddr", paddr, 32'h104);
        chk("b2b_setup2_pwdata", pwdata, 32'h22222222);
        @(negedge clk);
        pready = 1'b1;
        #1 chk("b2b_gap", rsp_valid, 0);
        chk("b2b_acc2_pen", penable, 1);
        @(negedge clk);
        pready = 1'b0;
        #1 chk("b2b_rsp2", rsp_valid, 1);
        chk("b2b_idle_psel", psel, 0);

        // reset during an ACCESS wait
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300;
        cmd_sel = 4'b0010; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("rstmid_pen", penable, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstmid_psel", psel, 0);
        chk("rstmid_penable", penable, 0);
        chk("rstmid_paddr", paddr, 0);
        chk("rstmid_rsp", rsp_valid, 0);
        chk("rstmid_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("rstmid_quiet", rsp_valid, 0);
        end
        run_vec(mk(1, 32'h40, 32'h0BADF00D, 4'b1000, 2, 32'h0, 0,
                   5, 0, 0, 32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
